sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
Boot/health sequencer for the 32-bit system-ID slave: an Avalon-MM read master that fetches the ID word (address 0) and the build-timestamp word (address 1). It compares both words against build-time expected values, retries on mismatch and times out on a stalled slave. Results are published to the CPU-independent status logic (LCD "bad image" indicator, reset supervisor), so the hardware/software build pairing is checked before the LCD controller is released.

Parameters:
EXPECTED_ID, 32'd12345678, value required at sysid address 0
EXPECTED_TS, 32'd1432136928, value required at sysid address 1
READ_LATENCY, 0, cycles from command acceptance to valid readdata (0..7)
TIMEOUT_CYCLES, 255, max consecutive waitrequest-high cycles per read (1..65535)
MAX_RETRIES, 2, extra full ID+TS passes after a mismatch (0..7)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to run a check
avm_address  out  1  sysid word select (0=ID, 1=TS)
avm_read  out  1  read command
avm_waitrequest  in  1  slave stall; tie 0 for the plain sysid slave
avm_readdata  in  32  slave read data
busy  out  1  check in progress
done  out  1  one-cycle pulse at completion
pass  out  1  last check matched both words
timeout  out  1  last check aborted on stall
id_value  out  32  last captured ID word
ts_value  out  32  last captured TS word

Behaviour:
- Interface: one clock, "clock"; reset "reset", synchronous, active-high.
- Reset: state IDLE; avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout=0, id_value=0, ts_value=0, retry and timeout counters=0. Reset mid-read drops avm_read on the next edge. No done pulse is issued.
- FSM states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, EVAL, FIN.
- IDLE: start=1 -> REQ_ID; clear retry count, pass and timeout; busy=1 from the next cycle. start while busy is ignored.
- REQ_x: avm_read=1, avm_address=0 (ID) or 1 (TS). The command is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
  - On acceptance with READ_LATENCY=0, readdata is captured the same cycle; go to the next REQ state or EVAL.
  - With READ_LATENCY>0, go to LAT_x. avm_read=0 in LAT_x; readdata is captured when the latency counter reaches READ_LATENCY.
- Timeout: a counter increments on each REQ cycle with waitrequest=1 and clears on acceptance. Reaching TIMEOUT_CYCLES sets timeout=1 and pass=0, drops avm_read and goes to FIN. There is no retry on timeout.
- EVAL (1 cycle): match = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS).
  - match -> pass=1, FIN.
  - mismatch with retry count < MAX_RETRIES -> count+1, REQ_ID.
  - mismatch otherwise -> pass=0, FIN.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. pass, timeout, id_value and ts_value hold until the next start.
- Latency, zero-wait, READ_LATENCY=0, start at cycle k:
  - REQ_ID at k+1, REQ_TS at k+2, EVAL at k+3, FIN/done at k+4.
  - Each retry adds 3 cycles.
  - Each latency stage adds READ_LATENCY cycles per read.
- Captures overwrite id_value/ts_value on every pass, including retries. Counters saturate and never wrap.

Decomposition:
- Shared package sysid_pkg:
  - state enum
  - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
  - default EXPECTED_ID/EXPECTED_TS constants, so the LCD software header generator and the RTL agree.
- One sub-module, sysid_rd_port: Avalon single-read engine (REQ/LAT handling, latency counter, timeout counter). Inputs: go and address. Outputs: data_valid, data and timed_out. The checker FSM drives it twice per pass.

Test Plan:
- Nominal: sysid model returns 12345678 / 1432136928, latency 0, no wait; pulse start at cycle 10 -> avm_read cycles 11-12 (address 0 then 1), done at cycle 14, pass=1, busy high cycles 11-13.
- Bad ID: model returns 0xDEADBEEF at address 0, MAX_RETRIES=2 -> 3 ID+TS passes (6 reads), done at start+10, pass=0, id_value=0xDEADBEEF.
- Stall: waitrequest held 1, TIMEOUT_CYCLES=4 -> avm_read high 4 cycles then low, timeout=1, pass=0, done one cycle later.
- Latency: READ_LATENCY=2 with waitrequest=1 for 3 cycles on the TS read -> correct capture, pass=1, done at start+11.
- Start while busy: second start at start+2 -> ignored, exactly one done pulse.
- Reset mid-op: assert reset during REQ_TS -> next edge avm_read=0, busy=0, pass=0, no done; a fresh start afterwards completes with pass=1.

Source files
------------

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared checker state encoding, sysid word addresses and default expected words
package sysid_pkg;
   typedef enum logic [2:0] {IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, EVAL, FIN} state_t;
   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;
   localparam logic [31:0] SYSID_EXPECTED_ID = 32'd12345678;
   localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1432136928;
endpackage

// File: rtl/sysid_rd_port.sv
// sysid_rd_port: Avalon-MM single-read engine with fixed read latency and stall timeout
module sysid_rd_port #(
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        go,
   input  logic        address,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        avm_read,
   output logic        avm_address,
   output logic        accepted,
   output logic        data_valid,
   output logic [31:0] data,
   output logic        timed_out
);
   logic        in_lat;
   logic [2:0]  lat_cnt;
   logic [15:0] wait_cnt;
   assign avm_read    = go && !in_lat;
   assign avm_address = address;
   assign accepted    = avm_read && !avm_waitrequest;
   assign data        = avm_readdata;
   assign data_valid  = (READ_LATENCY == 0) ? accepted : in_lat && (4'(lat_cnt) + 4'd1 == 4'(READ_LATENCY));
   assign timed_out   = avm_read && avm_waitrequest && (17'(wait_cnt) + 17'd1 >= 17'(TIMEOUT_CYCLES));
   // Dropping go between reads or on abort clears every counter, so each read starts fresh
   always_ff @(posedge clock) begin
      if (reset || !go) begin
         in_lat   <= 1'b0;
         lat_cnt  <= 3'd0;
         wait_cnt <= 16'd0;
      end else begin
         in_lat   <= in_lat ? !data_valid : (accepted && READ_LATENCY != 0);
         lat_cnt  <= in_lat ? lat_cnt + 3'd1 : 3'd0;
         wait_cnt <= (avm_read && avm_waitrequest && !timed_out) ? wait_cnt + 16'd1 : 16'd0;
      end
   end
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid ID/timestamp words, compares, retries on mismatch, aborts on stall
module sysid_checker import sysid_pkg::*; #(
   parameter logic [31:0] EXPECTED_ID = SYSID_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS = SYSID_EXPECTED_TS,
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRIES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);
   state_t      state, next;
   logic        go, rd_addr, accepted, data_valid, timed_out, match, retry;
   logic [31:0] data;
   logic [2:0]  retry_cnt;
   assign go      = state inside {REQ_ID, LAT_ID, REQ_TS, LAT_TS};
   assign rd_addr = (state == REQ_TS || state == LAT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
   assign match   = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
   assign retry   = !match && int'(retry_cnt) < MAX_RETRIES;
   assign busy    = go || state == EVAL;
   assign done    = state == FIN;
   sysid_rd_port #(.READ_LATENCY(READ_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
      .clock(clock), .reset(reset), .go(go), .address(rd_addr),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_read(avm_read), .avm_address(avm_address), .accepted(accepted),
      .data_valid(data_valid), .data(data), .timed_out(timed_out)
   );
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = start ? REQ_ID : IDLE;
         REQ_ID:  next = timed_out ? FIN : data_valid ? REQ_TS : accepted ? LAT_ID : REQ_ID;
         LAT_ID:  next = data_valid ? REQ_TS : LAT_ID;
         REQ_TS:  next = timed_out ? FIN : data_valid ? EVAL : accepted ? LAT_TS : REQ_TS;
         LAT_TS:  next = data_valid ? EVAL : LAT_TS;
         EVAL:    next = retry ? REQ_ID : FIN;
         FIN:     next = IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         id_value  <= 32'd0;
         ts_value  <= 32'd0;
         retry_cnt <= 3'd0;
      end else begin
         state <= next;
         if (state == IDLE && start) begin
            retry_cnt <= 3'd0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
         end
         if (data_valid && rd_addr == SYSID_ADDR_ID) id_value <= data;
         if (data_valid && rd_addr == SYSID_ADDR_TS) ts_value <= data;
         if (timed_out) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
         end
         if (state == EVAL) begin
            pass <= match;
            if (retry) retry_cnt <= retry_cnt + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed table, hand sequences and randomized runs against a pass-level model
module tb_sysid_checker;
   localparam logic [31:0] EXP_ID = 32'd12345678;
   localparam logic [31:0] EXP_TS = 32'd1432136928;
   localparam logic [31:0] BAD_ID = 32'hDEADBEEF;
   localparam logic [31:0] BAD_TS = 32'hBAADF00D;
   localparam logic [31:0] JUNK   = 32'h0BAD0BAD;
   localparam int TO = 4;
   localparam int MAXR = 2;
   localparam int LAT [2] = '{0, 2};

   typedef struct {
      int          j;
      logic [5:0]  okm;
      logic [23:0] stl;
      int          lat;
      bit          p;
      bit          t;
      logic [31:0] id;
      logic [31:0] ts;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start [2], rd [2], addr [2], wt [2], busy [2], done [2], pass [2], tmo [2];
   logic [31:0] rdata [2], idv [2], tsv [2];
   int st [2][8];
   bit ok [2][8];
   int sc [2], rn [2];
   logic [31:0] p1, p2;
   logic [31:0] m_id [2], m_ts [2];
   int tests = 0, fails = 0;
   vec_t vt [7];

   always #5 clk = ~clk;

   sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)) u0 (
      .clock(clk), .reset(reset), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
      .avm_waitrequest(wt[0]), .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0]));

   sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)) u1 (
      .clock(clk), .reset(reset), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
      .avm_waitrequest(wt[1]), .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1]));

   // Slave model: read n stalls st[j][n] cycles, then returns the good or bad word per ok[j][n]
   function automatic logic [31:0] word(int j, logic a, int n);
      return ok[j][n] ? (a ? EXP_TS : EXP_ID) : (a ? BAD_TS : BAD_ID);
   endfunction

   always_comb begin
      for (int j = 0; j < 2; j++) wt[j] = rd[j] && (sc[j] < st[j][rn[j]]);
      rdata[0] = !rd[0] ? JUNK : ok[0][rn[0]] ? (addr[0] ? EXP_TS : EXP_ID) : (addr[0] ? BAD_TS : BAD_ID);
      rdata[1] = p2;
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (reset || start[j]) begin
            sc[j] <= 0;
            rn[j] <= 0;
         end else if (rd[j] && wt[j]) begin
            sc[j] <= sc[j] + 1;
         end else begin
            sc[j] <= 0;
            if (rd[j]) rn[j] <= rn[j] + 1;
         end
      end
      p1 <= (rd[1] && !wt[1]) ? word(1, addr[1], rn[1]) : JUNK;
      p2 <= p1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int j, input logic [5:0] okm, input logic [23:0] stl);
      for (int n = 0; n < 8; n++) begin
         st[j][n] = (n < 6) ? int'(stl[n*4 +: 4]) : 0;
         ok[j][n] = (n < 6) ? okm[n] : 1'b1;
      end
   endtask

   // Pass-level model: walk reads in order, accumulating cycle cost, until match, retries exhausted or timeout
   task automatic model(input int j, output int dl, output bit p, output bit t);
      int c = 1;
      int n = 0;
      p = 1'b0;
      t = 1'b0;
      dl = 0;
      for (int ps = 0; ps <= MAXR; ps++) begin
         for (int a = 0; a < 2; a++) begin
            if (st[j][n] >= TO) begin
               t = 1'b1;
               dl = c + TO;
               return;
            end
            c += 1 + st[j][n] + LAT[j];
            if (a == 0) m_id[j] = ok[j][n] ? EXP_ID : BAD_ID;
            else m_ts[j] = ok[j][n] ? EXP_TS : BAD_TS;
            n++;
         end
         c++;
         if (m_id[j] == EXP_ID && m_ts[j] == EXP_TS) begin
            p = 1'b1;
            break;
         end
      end
      dl = c;
   endtask

   task automatic run_test(input int j, input string tag, input int elat, input bit ep, input bit et,
                           input logic [31:0] eid, input logic [31:0] ets);
      int lat = 0;
      start[j] = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         start[j] = 1'b0;
         if (done[j]) begin
            lat = i;
            break;
         end
      end
      chk({tag, " done_latency"}, lat, elat);
      chk({tag, " pass"}, pass[j], ep);
      chk({tag, " timeout"}, tmo[j], et);
      chk({tag, " id_value"}, idv[j], eid);
      chk({tag, " ts_value"}, tsv[j], ets);
      chk({tag, " busy_at_done"}, busy[j], 1'b0);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, done[j], 1'b0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int dl, nd, first;
      bit p, t;
      start[0] = 1'b0;
      start[1] = 1'b0;
      load(0, 6'h3F, 24'h0);
      load(1, 6'h3F, 24'h0);
      vt[0] = '{0, 6'h3F,     24'h000000, 4,  1'b1, 1'b0, EXP_ID, EXP_TS};
      vt[1] = '{0, 6'b101010, 24'h000000, 10, 1'b0, 1'b0, BAD_ID, EXP_TS};
      vt[2] = '{0, 6'h3F,     24'h00000F, 5,  1'b0, 1'b1, BAD_ID, EXP_TS};
      vt[3] = '{0, 6'h3F,     24'h000003, 7,  1'b1, 1'b0, EXP_ID, EXP_TS};
      vt[4] = '{0, 6'b111110, 24'h004000, 9,  1'b0, 1'b1, EXP_ID, EXP_TS};
      vt[5] = '{1, 6'h3F,     24'h000030, 11, 1'b1, 1'b0, EXP_ID, EXP_TS};
      vt[6] = '{1, 6'b111101, 24'h000000, 15, 1'b1, 1'b0, EXP_ID, EXP_TS};
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         chk("reset avm_read", rd[j], 1'b0);
         chk("reset avm_address", addr[j], 1'b0);
         chk("reset busy", busy[j], 1'b0);
         chk("reset done", done[j], 1'b0);
         chk("reset pass", pass[j], 1'b0);
         chk("reset timeout", tmo[j], 1'b0);
         chk("reset id_value", idv[j], 32'd0);
         chk("reset ts_value", tsv[j], 32'd0);
         m_id[j] = 32'd0;
         m_ts[j] = 32'd0;
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Nominal cycle-by-cycle bus sequence
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      chk("nom k+1 avm_read", rd[0], 1'b1);
      chk("nom k+1 address", addr[0], 1'b0);
      chk("nom k+1 busy", busy[0], 1'b1);
      @(posedge clk); #1;
      chk("nom k+2 avm_read", rd[0], 1'b1);
      chk("nom k+2 address", addr[0], 1'b1);
      @(posedge clk); #1;
      chk("nom k+3 avm_read", rd[0], 1'b0);
      chk("nom k+3 busy", busy[0], 1'b1);
      chk("nom k+3 done", done[0], 1'b0);
      @(posedge clk); #1;
      chk("nom k+4 done", done[0], 1'b1);
      chk("nom k+4 busy", busy[0], 1'b0);
      chk("nom k+4 pass", pass[0], 1'b1);
      @(posedge clk); #1;
      chk("nom k+5 done", done[0], 1'b0);
      repeat (2) @(posedge clk);
      #1;

      foreach (vt[v]) begin
         load(vt[v].j, vt[v].okm, vt[v].stl);
         run_test(vt[v].j, $sformatf("vec%0d", v), vt[v].lat, vt[v].p, vt[v].t, vt[v].id, vt[v].ts);
         m_id[vt[v].j] = vt[v].id;
         m_ts[vt[v].j] = vt[v].ts;
      end

      // Start while busy is ignored: one done, at the original latency
      load(0, 6'h3F, 24'h0);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      @(posedge clk); #1;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      nd = 0;
      first = 0;
      for (int i = 3; i <= 17; i++) begin
         if (done[0]) begin
            nd++;
            if (first == 0) first = i;
         end
         @(posedge clk); #1;
      end
      chk("busy_start done_count", nd, 1);
      chk("busy_start done_cycle", first, 4);
      m_id[0] = EXP_ID;
      m_ts[0] = EXP_TS;

      // Reset during the TS read
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      @(posedge clk); #1;
      chk("midrst in REQ_TS", {rd[0], addr[0]}, 2'b11);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst avm_read", rd[0], 1'b0);
      chk("midrst busy", busy[0], 1'b0);
      chk("midrst pass", pass[0], 1'b0);
      chk("midrst done", done[0], 1'b0);
      reset = 1'b0;
      nd = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done[0]) nd++;
      end
      chk("midrst no_done", nd, 0);
      for (int j = 0; j < 2; j++) begin
         m_id[j] = 32'd0;
         m_ts[j] = 32'd0;
      end
      run_test(0, "post_reset", 4, 1'b1, 1'b0, EXP_ID, EXP_TS);
      m_id[0] = EXP_ID;
      m_ts[0] = EXP_TS;

      for (int r = 0; r < 40; r++) begin
         int j;
         j = int'($urandom_range(0, 1));
         for (int n = 0; n < 8; n++) begin
            st[j][n] = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, TO - 1));
            ok[j][n] = ($urandom_range(0, 3) != 0);
         end
         model(j, dl, p, t);
         run_test(j, $sformatf("rand%0d_u%0d", r, j), dl, p, t, m_id[j], m_ts[j]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
